// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the capture controller: FSM state encoding,
// restart request codes and err_flags bit positions.
package capture_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_CONFIG     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_EXE        = 3'd3,
        ST_FINISH     = 3'd4
    } state_t;

    localparam logic [1:0] RESTART_REDO     = 2'd0;
    localparam logic [1:0] RESTART_RECONFIG = 2'd1;
    localparam logic [1:0] RESTART_CLOSE    = 2'd2;

    localparam int ERR_W         = 5;
    localparam int ERR_START_OP  = 0;
    localparam int ERR_IN_VLD    = 1;
    localparam int ERR_RESTART   = 2;
    localparam int ERR_START_CFG = 3;
    localparam int ERR_DEPTH     = 4;

endpackage

// File: rtl/capture_decim.sv
// Per-channel decimator: keeps one of every (decim_i+1) valid samples.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   active_i   - decimator counts only while high
//   clr_i      - restart the phase at 0 (capture start)
//   decim_i    - latched decimation value
//   vld_i      - incoming sample valid
//   keep_o     - current sample is kept
module capture_decim #(
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   active_i,
    input  logic                   clr_i,
    input  logic [DECIM_WIDTH-1:0] decim_i,
    input  logic                   vld_i,
    output logic                   keep_o
);

    logic [DECIM_WIDTH-1:0] phase_q;

    assign keep_o = active_i && vld_i && (phase_q == '0);

    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            phase_q <= '0;
        end else if (active_i && vld_i) begin
            phase_q <= (phase_q == decim_i) ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl_mc.sv
// Multi-channel capture controller. Sequences firmware handshakes
// (IDLE/CONFIG/WAIT_START/EXE/FINISH), latches run-time configuration,
// decimates each channel and produces per-channel buffer writes.
// Ports:
//   start_config/cfg_*     - configuration request and values (IDLE only)
//   phase_inc_out/_vld     - latched NCO increment, valid during CONFIG
//   start_op/abort         - capture start / abort
//   restart_vld/_type      - post-capture restart request (FINISH only)
//   in_data/in_vld         - flattened per-channel samples
//   out_data/out_vld/out_addr/data_count - per-channel write port, counts
//   clken/busy/finish_op   - status
//   err_flags/err_clr      - sticky error flags and clear
module capture_ctrl_mc
    import capture_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DEPTH       = 1024,
    parameter int PHASE_INC_WIDTH = 16,
    parameter int CONFIG_CYCLES   = 4,
    parameter int DECIM_WIDTH     = 8,
    localparam int AW             = $clog2(MAX_DEPTH),
    localparam int CW             = AW + 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_config,
    input  logic [PHASE_INC_WIDTH-1:0]   cfg_phase_inc,
    input  logic [CW-1:0]                cfg_depth,
    input  logic [DECIM_WIDTH-1:0]       cfg_decim,
    output logic [PHASE_INC_WIDTH-1:0]   phase_inc_out,
    output logic                         phase_inc_vld,
    input  logic                         start_op,
    input  logic                         abort,
    input  logic                         restart_vld,
    input  logic [1:0]                   restart_type,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_vld,
    output logic [NUM_CH*AW-1:0]         out_addr,
    output logic [NUM_CH*CW-1:0]         data_count,
    output logic                         clken,
    output logic                         busy,
    output logic                         finish_op,
    output logic [ERR_W-1:0]             err_flags,
    input  logic                         err_clr
);

    state_t                  state_q, state_d;
    logic [3:0]              cfg_cnt_q;
    logic [CW-1:0]           depth_q;
    logic [DECIM_WIDTH-1:0]  decim_q;
    logic [PHASE_INC_WIDTH-1:0] phase_inc_q;
    logic [ERR_W-1:0]        err_q, err_set;

    logic [CW-1:0]           count_q [NUM_CH];
    logic [AW-1:0]           addr_q  [NUM_CH];
    logic [DATA_WIDTH-1:0]   wdata_q [NUM_CH];
    logic [NUM_CH-1:0]       out_vld_q;
    logic [NUM_CH-1:0]       keep, wr_en;

    logic cfg_load, cfg_reset, depth_bad, exe_entry, all_done;

    assign cfg_load  = (state_q == ST_IDLE) && start_config;
    assign cfg_reset = (state_q == ST_FINISH) && restart_vld && (restart_type == RESTART_CLOSE);
    assign depth_bad = (cfg_depth == '0) || (cfg_depth > CW'(MAX_DEPTH));
    assign exe_entry = (state_q == ST_WAIT_START) && start_op && !abort;

    always_comb begin
        all_done = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (count_q[k] != depth_q) all_done = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start_config) state_d = ST_CONFIG;
            ST_CONFIG:     if (abort) state_d = ST_IDLE;
                           else if (cfg_cnt_q == 4'(CONFIG_CYCLES - 1)) state_d = ST_WAIT_START;
            ST_WAIT_START: if (abort) state_d = ST_IDLE;
                           else if (start_op) state_d = ST_EXE;
            ST_EXE:        if (abort) state_d = ST_IDLE;
                           else if (all_done) state_d = ST_FINISH;
            ST_FINISH: begin
                if (restart_vld) begin
                    case (restart_type)
                        RESTART_REDO:     state_d = ST_WAIT_START;
                        RESTART_RECONFIG: state_d = ST_IDLE;
                        RESTART_CLOSE:    state_d = ST_IDLE;
                        default:          state_d = ST_FINISH;
                    endcase
                end
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cfg_cnt_q   <= '0;
            depth_q     <= CW'(MAX_DEPTH);
            decim_q     <= '0;
            phase_inc_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_cnt_q <= (state_q == ST_CONFIG && state_d == ST_CONFIG) ? cfg_cnt_q + 1'b1 : '0;
            if (cfg_load) begin
                depth_q     <= depth_bad ? CW'(MAX_DEPTH) : cfg_depth;
                decim_q     <= cfg_decim;
                phase_inc_q <= cfg_phase_inc;
            end else if (cfg_reset) begin
                depth_q     <= CW'(MAX_DEPTH);
                decim_q     <= '0;
                phase_inc_q <= '0;
            end
        end
    end

    // Errors raised this cycle are OR-ed in after the clear so they survive it.
    always_comb begin
        err_set                = '0;
        err_set[ERR_START_OP]  = start_op && (state_q != ST_WAIT_START);
        err_set[ERR_IN_VLD]    = (|in_vld) && (state_q != ST_EXE) && (state_q != ST_FINISH);
        err_set[ERR_RESTART]   = restart_vld && ((state_q != ST_FINISH) || (restart_type == 2'd3));
        err_set[ERR_START_CFG] = start_config && (state_q != ST_IDLE);
        err_set[ERR_DEPTH]     = cfg_load && depth_bad;
    end

    always_ff @(posedge clk) begin
        if (!rstn) err_q <= '0;
        else       err_q <= (err_clr ? '0 : err_q) | err_set;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        capture_decim #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
            .clk      (clk),
            .rstn     (rstn),
            .active_i (state_q == ST_EXE),
            .clr_i    (exe_entry),
            .decim_i  (decim_q),
            .vld_i    (in_vld[k]),
            .keep_o   (keep[k])
        );
        // No write in an abort cycle so the count freezes at its current value.
        assign wr_en[k] = keep[k] && !abort && (count_q[k] < depth_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                count_q[k] <= '0;
                addr_q[k]  <= '0;
                wdata_q[k] <= '0;
            end
        end else if (exe_entry) begin
            out_vld_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                count_q[k] <= '0;
                addr_q[k]  <= '0;
            end
        end else begin
            out_vld_q <= wr_en;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) begin
                    wdata_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    addr_q[k]  <= count_q[k][AW-1:0];
                    count_q[k] <= count_q[k] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        out_data   = '0;
        out_addr   = '0;
        data_count = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = wdata_q[k];
            out_addr[k*AW +: AW]                 = addr_q[k];
            data_count[k*CW +: CW]               = count_q[k];
        end
    end

    assign out_vld       = out_vld_q;
    assign phase_inc_out = phase_inc_q;
    assign phase_inc_vld = (state_q == ST_CONFIG);
    assign clken         = (state_q == ST_EXE);
    assign busy          = (state_q == ST_CONFIG) || (state_q == ST_WAIT_START) || (state_q == ST_EXE);
    assign finish_op     = (state_q == ST_FINISH);
    assign err_flags     = err_q;

endmodule

// File: doc/capture_ctrl_mc.md
Name: capture_ctrl_mc

Overview:
Next-generation capture controller for the phase-noise measurement datapath. It sequences firmware handshakes through the states IDLE, CONFIG, WAIT_START, EXE and FINISH, for NUM_CH input channels. Each channel passes through a decimator, then writes into a capture buffer sized at run time. Run-time capture depth, run-time decimation, firmware abort and sticky error flags are new in this generation. The block sits between the ADC/NCO front end and the per-channel BRAM capture buffers read by firmware.

Parameters:
NUM_CH, 2, number of input channels (1..8)
DATA_WIDTH, 32, sample width per channel
MAX_DEPTH, 1024, maximum samples per channel (power of 2)
PHASE_INC_WIDTH, 16, NCO phase-increment width
CONFIG_CYCLES, 4, cycles spent in CONFIG (2..15)
DECIM_WIDTH, 8, width of decimation control

Derived widths: AW = clog2(MAX_DEPTH); CW = AW+1.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start_config  in  1  request configuration; sampled only in IDLE
cfg_phase_inc  in  PHASE_INC_WIDTH  NCO increment; latched with start_config
cfg_depth  in  CW  samples per channel; latched with start_config
cfg_decim  in  DECIM_WIDTH  keep 1 of (cfg_decim+1) valid samples; latched with start_config
phase_inc_out  out  PHASE_INC_WIDTH  latched increment
phase_inc_vld  out  1  high throughout CONFIG
start_op  in  1  start capture; accepted only in WAIT_START
abort  in  1  abort capture
restart_vld  in  1  restart request; accepted only in FINISH
restart_type  in  2  0 REDO, 1 RECONFIG, 2 CLOSE, 3 invalid
in_data  in  NUM_CH*DATA_WIDTH  flattened samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
in_vld  in  NUM_CH  per-channel sample valid
out_data  out  NUM_CH*DATA_WIDTH  registered write data
out_vld  out  NUM_CH  write enable
out_addr  out  NUM_CH*AW  write address
data_count  out  NUM_CH*CW  samples written in the current run
clken  out  1  high in EXE
busy  out  1  high in CONFIG, WAIT_START and EXE
finish_op  out  1  high in FINISH
err_flags  out  5  sticky error bits
err_clr  in  1  clears err_flags

Behaviour:
- Reset: state IDLE; all outputs 0; latched depth = MAX_DEPTH; latched decimation = 0; latched phase increment = 0; all counters 0.
- IDLE -> CONFIG on start_config. In that same cycle, latch the configuration.
  - cfg_depth = 0 or cfg_depth > MAX_DEPTH: latch MAX_DEPTH and set err_flags[4].
- CONFIG: a counter runs 0..CONFIG_CYCLES-1. The FSM moves to WAIT_START in the cycle after the counter reaches CONFIG_CYCLES-1.
- WAIT_START -> EXE on start_op. On entry to EXE, clear per-channel counts, addresses and decimator phase.
- EXE -> FINISH when every channel's count equals the latched depth.
- FINISH, on restart_vld:
  - REDO -> WAIT_START; the configuration is kept.
  - RECONFIG -> IDLE.
  - CLOSE -> IDLE and the latched configuration returns to its reset values.
  - type 3 -> stay in FINISH and set err_flags[2].
- abort in CONFIG, WAIT_START or EXE -> IDLE the next cycle. Counts freeze and the configuration is kept. abort has priority over every other transition in the same cycle.
- Decimator, per channel: counts in_vld pulses from 0 to the latched decimation value.
  - A sample is kept when the count is 0.
  - After the latched-decimation-th pulse the count wraps to 0.
  - The decimator is active only in EXE.
- Write path:
  - A kept sample on channel k with count_k < depth is registered. One cycle later out_vld[k]=1, out_data = that sample and out_addr = count_k before the increment; count_k increments in the same cycle.
  - Once count_k reaches depth, that channel ignores further samples while the other channels continue.
  - Write latency is 1 cycle from in_vld.
  - Outside EXE, out_vld = 0 and in_vld is ignored (no writes, no count changes).
- Counters: count_k never exceeds depth. Addresses stay in 0..depth-1 and never wrap.
- data_count holds its value through FINISH and IDLE. It clears only on EXE entry.
- err_flags (sticky; set has priority over err_clr in the same cycle):
  - [0] start_op outside WAIT_START
  - [1] any in_vld outside EXE, except in FINISH
  - [2] restart_vld outside FINISH, or restart_type 3
  - [3] start_config outside IDLE
  - [4] illegal cfg_depth
- Illegal state encoding -> IDLE.

Decomposition:
- Package capture_ctrl_pkg:
  - state encoding (IDLE=0 … FINISH=4) and state width
  - restart-type constants (REDO, RECONFIG, CLOSE)
  - err_flags bit indices
- Sub-module capture_decim: one instance per channel via generate. It holds the decimation counter, the keep decision and the enable gating.
- FSM, configuration latch and write registers stay in the top module.

Test Plan:
- NUM_CH=2, start_config with cfg_depth=8 and cfg_decim=0, wait 4 cycles, start_op, continuous in_vld on both channels -> out_addr runs 0..7 on each channel, data_count=8, finish_op high the cycle after the last write, and no writes beyond 8.
- cfg_decim=2, in_vld every cycle with in_data = cycle index -> the written samples are indices 0,3,6,… and out_vld has a 1/3 duty cycle.
- Channel 0 fed at full rate, channel 1 at half rate, depth 4 -> channel 0 stops at count 4 while channel 1 continues; finish only after channel 1 reaches 4.
- abort asserted mid-EXE at count 3 -> IDLE next cycle, data_count stays 3. start_config then REDO-style capture -> counts clear on EXE entry.
- In FINISH, restart types 0/1/2/3 -> WAIT_START / IDLE / IDLE with depth back to MAX_DEPTH / stay in FINISH with err_flags[2]=1.
- cfg_depth=0, start_op in IDLE, in_vld in WAIT_START, err_clr coincident with a new error -> err_flags bits 4, 0 and 1 set; the bit set in the coincident cycle survives err_clr.
